cu_cond_logic: RTL

CU_COND_LOGIC -- requirements
Module: cu_cond_logic

---
 rtl/cu_cond_logic_if.sv | 30 +++
 rtl/cu_cond_logic.sv | 114 +++++++++++
 2 files changed

// File: rtl/cu_cond_logic_if.sv
// Execute-stage control bundle between the decoder/condition checker and the
// conditional-execution block.
interface cu_cond_logic_if;
  logic       InValid;
  logic       Stall;
  logic       CondEx;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [1:0] FlagsA;
  logic [1:0] FlagsB;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       OutValid;
  logic       Squash;

  modport master (
    output InValid, Stall, CondEx, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  FlagsA, FlagsB, PCSrc, RegWrite, MemWrite, OutValid, Squash
  );

  modport slave (
    input  InValid, Stall, CondEx, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output FlagsA, FlagsB, PCSrc, RegWrite, MemWrite, OutValid, Squash
  );
endinterface

// File: rtl/cu_cond_logic.sv
// Conditional-execution gate: holds the architectural flags, gates write/branch
// controls by the condition result and squashes slots after a taken branch.
module cu_cond_logic #(
  parameter int unsigned SQUASH_SLOTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  cu_cond_logic_if.slave bus
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned FLAG_W = 2;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLAG_W-1:0]  flags_a_q, flags_a_d;
  logic [FLAG_W-1:0]  flags_b_q, flags_b_d;
  logic               pcsrc_q, pcsrc_d;
  logic               regwrite_q, regwrite_d;
  logic               memwrite_q, memwrite_d;
  logic               outvalid_q, outvalid_d;

  logic accept_c;
  logic exec_c;

  // Stall or an active squash makes the instruction invisible to everything below.
  assign accept_c = bus.InValid && !bus.Stall && (state_q == RUN);
  assign exec_c   = accept_c && bus.CondEx;

  // State register: FSM, slot counter, flags and gated controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      flags_a_q  <= '0;
      flags_b_q  <= '0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      outvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_a_q  <= flags_a_d;
      flags_b_q  <= flags_b_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      outvalid_q <= outvalid_d;
    end
  end

  // Next-state: a taken branch arms the counter; each unstalled squash cycle burns one slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.Stall) begin
      case (state_q)
        RUN: begin
          if (exec_c && bus.PCS) begin
            state_d = SQUASH;
            cnt_d   = CNT_W'(SQUASH_SLOTS);
          end
        end
        SQUASH: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output next values; everything holds while stalled.
  always_comb begin
    flags_a_d  = flags_a_q;
    flags_b_d  = flags_b_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    outvalid_d = outvalid_q;
    if (!bus.Stall) begin
      if (exec_c && bus.FlagW[1]) begin
        flags_a_d = bus.ALUFlags[3:2];
      end
      if (exec_c && bus.FlagW[0]) begin
        flags_b_d = bus.ALUFlags[1:0];
      end
      regwrite_d = exec_c && bus.RegW && !bus.NoWrite;
      memwrite_d = exec_c && bus.MemW;
      pcsrc_d    = exec_c && bus.PCS;
      outvalid_d = accept_c;
    end
  end

  assign bus.FlagsA   = flags_a_q;
  assign bus.FlagsB   = flags_b_q;
  assign bus.PCSrc    = pcsrc_q;
  assign bus.RegWrite = regwrite_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.OutValid = outvalid_q;
  assign bus.Squash   = (state_q == SQUASH);

endmodule
